// File: rtl/blink_select_n_pkg.sv
// Shared sizing helpers for the blink selector: selector width and per-channel half-periods.
package blink_select_n_pkg;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Width of a counter or index that must hold values 0..n-1, never narrower than one bit.
  function automatic int min1_width(input int n);
    return (clog2_f(n) < 1) ? 1 : clog2_f(n);
  endfunction

  function automatic int sel_width(input int num_ch);
    return min1_width(num_ch);
  endfunction

  function automatic int ch_limit(input int base_limit, input int k);
    return base_limit >> k;
  endfunction

endpackage

// File: rtl/blink_channel.sv
// One free-running square wave: toggles every LIMIT enabled clocks.
// Output is the toggle flop itself; i_Enable low freezes counter and toggle.
module blink_channel
  import blink_select_n_pkg::*;
#(
  parameter int LIMIT = 2
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Enable,
  output logic o_Toggle
);

  localparam int CNT_W = min1_width(LIMIT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      cnt      <= '0;
      o_Toggle <= 1'b0;
    end else if (i_Enable) begin
      if (cnt == CNT_W'(LIMIT - 1)) begin
        cnt      <= '0;
        o_Toggle <= ~o_Toggle;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/blink_select_n.sv
// Debounced NUM_CH-way blink selector with runt-free handover; o_LED is one clock behind the toggle.
// No backpressure: selector changes wait for debounce plus a moment when both sources are low.
module blink_select_n
  import blink_select_n_pkg::*;
#(
  parameter int  NUM_CH         = 4,
  parameter int  BASE_LIMIT     = 12500000,
  parameter int  DEBOUNCE_LIMIT = 250000,
  localparam int SEL_W          = sel_width(NUM_CH)
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic [SEL_W-1:0] i_Sel,
  input  logic             i_Enable,
  output logic             o_LED,
  output logic [SEL_W-1:0] o_Sel_Active,
  output logic             o_Switching
);

  localparam int DB_W = min1_width(DEBOUNCE_LIMIT);
  localparam int NSRC = 1 << SEL_W;

  logic [NUM_CH-1:0] tog;
  logic [NSRC-1:0]   src_vec;
  logic [SEL_W-1:0]  sync_meta;
  logic [SEL_W-1:0]  sync_sel;
  logic [SEL_W-1:0]  stable_sel;
  logic [DB_W-1:0]   db_cnt;
  logic              cur_src;
  logic              tgt_src;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    blink_channel #(
      .LIMIT(ch_limit(BASE_LIMIT, k))
    ) u_ch (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .i_Enable(i_Enable),
      .o_Toggle(tog[k])
    );
  end

  // Indices past NUM_CH map onto constant-0 "off" sources.
  always_comb begin
    src_vec             = '0;
    src_vec[NUM_CH-1:0] = tog;
  end

  assign cur_src = src_vec[o_Sel_Active];
  assign tgt_src = src_vec[stable_sel];

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      sync_meta    <= '0;
      sync_sel     <= '0;
      stable_sel   <= '0;
      db_cnt       <= '0;
      o_Sel_Active <= '0;
      o_Switching  <= 1'b0;
      o_LED        <= 1'b0;
    end else begin
      sync_meta <= i_Sel;
      sync_sel  <= sync_meta;

      // The counter restarts on the edge where sync_sel takes a new value.
      if (sync_sel == stable_sel || sync_meta != sync_sel) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_LIMIT - 1)) begin
        stable_sel <= sync_sel;
        db_cnt     <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end

      if (stable_sel != o_Sel_Active && !cur_src && !tgt_src)
        o_Sel_Active <= stable_sel;

      o_Switching <= (stable_sel != o_Sel_Active);
      o_LED       <= i_Enable & cur_src;
    end
  end

endmodule

// File: tb/tb_blink_select_n.sv
// Directed bench: expectations are queued with their due cycle and checked as the run reaches them.
module tb_blink_select_n;

  localparam int S_LED  = 0;
  localparam int S_ACT  = 1;
  localparam int S_SW   = 2;
  localparam int S_LED3 = 3;
  localparam int S_ACT3 = 4;
  localparam int S_SW3  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic       en3 = 1'b1;
  logic [1:0] sel = 2'd0;
  logic [1:0] sel3 = 2'd0;
  logic       led, sw, led3, sw3;
  logic [1:0] act, act3;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int    at;
    int    sig;
    int    val;
    string tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  blink_select_n #(
    .NUM_CH(4), .BASE_LIMIT(16), .DEBOUNCE_LIMIT(4)
  ) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Sel(sel), .i_Enable(en),
    .o_LED(led), .o_Sel_Active(act), .o_Switching(sw)
  );

  blink_select_n #(
    .NUM_CH(3), .BASE_LIMIT(16), .DEBOUNCE_LIMIT(4)
  ) dut3 (
    .i_Clk(clk), .i_Reset(rst), .i_Sel(sel3), .i_Enable(en3),
    .o_LED(led3), .o_Sel_Active(act3), .o_Switching(sw3)
  );

  function automatic logic [7:0] obs(input int sig);
    case (sig)
      S_LED:   return {7'd0, led};
      S_ACT:   return {6'd0, act};
      S_SW:    return {7'd0, sw};
      S_LED3:  return {7'd0, led3};
      S_ACT3:  return {6'd0, act3};
      default: return {7'd0, sw3};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    total++;
    assert (o === e)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, o, e, cyc);
    end
  endtask

  task automatic expect_at(input int at, input int sig, input int val, input string tag);
    exp_t e;
    e.at  = at;
    e.sig = sig;
    e.val = val;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_due();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        chk(sb[i].tag, obs(sb[i].sig), 8'(sb[i].val));
        sb.delete(i);
      end
    end
  endtask

  task automatic run_to(input int n);
    while (cyc < n) begin
      @(negedge clk);
      check_due();
    end
  endtask

  task automatic drain(input string tag);
    chk(tag, 8'(sb.size()), 8'd0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_led",  obs(S_LED), 8'd0);
    chk("rst_act",  obs(S_ACT), 8'd0);
    chk("rst_sw",   obs(S_SW),  8'd0);
    chk("rst_led3", obs(S_LED3), 8'd0);
    chk("rst_act3", obs(S_ACT3), 8'd0);
    chk("rst_sw3",  obs(S_SW3),  8'd0);
    rst = 1'b0;

    // Channel 0 blinking from reset
    expect_at(5,  S_ACT, 0, "t1_act");
    expect_at(5,  S_SW,  0, "t1_sw");
    expect_at(16, S_LED, 0, "t1_led_pre_rise");
    expect_at(17, S_LED, 1, "t1_led_rise");
    expect_at(32, S_LED, 1, "t1_led_high_end");
    expect_at(33, S_LED, 0, "t1_led_fall");
    expect_at(48, S_LED, 0, "t1_led_low_end");
    expect_at(49, S_LED, 1, "t1_led_rise2");

    // Short glitch on the selector must not change anything
    for (int c = 22; c <= 30; c++) expect_at(c, S_SW, 0, "glitch_sw");
    expect_at(30, S_ACT, 0, "glitch_act");
    run_to(20);
    sel = 2'd2;
    run_to(23);
    sel = 2'd0;

    // Select channel 3 on the main DUT and "off" on the 3-channel DUT
    expect_at(46, S_SW,  0, "t2_sw_before");
    expect_at(47, S_SW,  1, "t2_sw_set");
    expect_at(64, S_ACT, 0, "t2_act_wait");
    expect_at(64, S_SW,  1, "t2_sw_wait");
    expect_at(64, S_LED, 1, "t2_led_ch0");
    expect_at(65, S_ACT, 3, "t2_act_handover");
    expect_at(65, S_SW,  1, "t2_sw_last");
    expect_at(65, S_LED, 0, "t2_led_gap");
    expect_at(66, S_SW,  0, "t2_sw_clear");
    expect_at(66, S_LED, 0, "t2_led_66");
    expect_at(67, S_LED, 1, "t2_led_67");
    expect_at(68, S_LED, 1, "t2_led_68");
    expect_at(69, S_LED, 0, "t2_led_69");
    expect_at(70, S_LED, 0, "t2_led_70");
    expect_at(71, S_LED, 1, "t2_led_71");
    expect_at(46, S_ACT3, 0, "off_act_before");
    expect_at(47, S_ACT3, 3, "off_act_after");
    expect_at(47, S_SW3,  1, "off_sw_set");
    expect_at(48, S_SW3,  0, "off_sw_clear");
    expect_at(50, S_LED3, 0, "off_led_50");
    expect_at(56, S_LED3, 0, "off_led_56");
    expect_at(60, S_LED3, 0, "off_led_60");
    expect_at(70, S_LED3, 0, "off_led_70");
    run_to(40);
    sel  = 2'd3;
    sel3 = 2'd3;

    // Freeze with LED high, then resume from the frozen counters
    run_to(71);
    en = 1'b0;
    expect_at(72, S_LED, 0, "frz_led_off");
    expect_at(80, S_LED, 0, "frz_led_80");
    expect_at(91, S_LED, 0, "frz_led_91");
    expect_at(91, S_ACT, 3, "frz_act");
    expect_at(92, S_LED, 1, "resume_92");
    expect_at(93, S_LED, 0, "resume_93");
    expect_at(94, S_LED, 0, "resume_94");
    expect_at(95, S_LED, 1, "resume_95");
    run_to(91);
    en = 1'b1;

    // Start a switch back to channel 0, then reset while it is pending
    expect_at(106, S_SW,  0, "t6_sw_before");
    expect_at(107, S_SW,  1, "t6_sw_set");
    expect_at(110, S_SW,  1, "t6_sw_pending");
    expect_at(110, S_ACT, 3, "t6_act_pending");
    run_to(100);
    sel = 2'd0;
    run_to(110);
    drain("sb_empty_1");

    #2 rst = 1'b1;
    #1;
    chk("arst_led", obs(S_LED), 8'd0);
    chk("arst_act", obs(S_ACT), 8'd0);
    chk("arst_sw",  obs(S_SW),  8'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Blinking restarts exactly as after the first reset
    expect_at(5,  S_ACT, 0, "t7_act");
    expect_at(5,  S_SW,  0, "t7_sw");
    expect_at(16, S_LED, 0, "t7_led_pre_rise");
    expect_at(17, S_LED, 1, "t7_led_rise");
    expect_at(32, S_LED, 1, "t7_led_high_end");
    expect_at(33, S_LED, 0, "t7_led_fall");
    run_to(40);
    drain("sb_empty_2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
